// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: radix-2 iterative multiply/divide engine producing the {hi,lo}
// pair for the HI/LO stage. Signed ops run on magnitudes and are fixed up in SIGN.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one shift-add (mul) or shift-subtract (div) step per cycle, DATA_W cycles
// SIGN  | sign fix-up of product / quotient / remainder, hi/lo loaded on exit
// DONE  | hi/lo just updated, done high; start accepted again
module alu_muldiv_seq #(
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] data1,
   input  logic [DATA_W-1:0] data2,
   input  logic              flush,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);
   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_SIGN = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                is_div_q, is_div_d;
   logic                neg_res_q, neg_res_d;
   logic                neg_rem_q, neg_rem_d;
   logic                div0_q, div0_d;
   logic [DATA_W-1:0]   dvsr_q, dvsr_d;
   logic [2*DATA_W:0]   acc_q, acc_d;
   logic [DATA_W:0]     rem_q, rem_d;
   logic [DATA_W-1:0]   hi_q, hi_d;
   logic [DATA_W-1:0]   lo_q, lo_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   // Operand magnitudes; the most negative value maps onto 2^(W-1) unsigned.
   logic              a_neg, b_neg;
   logic [DATA_W-1:0] a_mag, b_mag;
   assign a_neg = op[0] & data1[DATA_W-1];
   assign b_neg = op[0] & data2[DATA_W-1];
   assign a_mag = a_neg ? -data1 : data1;
   assign b_mag = b_neg ? -data2 : data2;

   // Multiply step: add multiplicand into the upper half (with carry), shift right.
   logic [DATA_W:0]   mul_sum;
   logic [2*DATA_W:0] mul_next;
   assign mul_sum  = acc_q[2*DATA_W:DATA_W] + (acc_q[0] ? {1'b0, dvsr_q} : '0);
   assign mul_next = {1'b0, mul_sum, acc_q[DATA_W-1:1]};

   // Divide step: shift next dividend bit into the remainder, trial subtract.
   // The extra top bit of div_diff is the borrow.
   logic [DATA_W+1:0] div_shift, div_diff;
   logic              div_ge;
   assign div_shift = {rem_q, acc_q[DATA_W-1]};
   assign div_diff  = div_shift - {2'b00, dvsr_q};
   assign div_ge    = ~div_diff[DATA_W+1];

   // Sign fix-up; divide by zero forces an all-ones quotient.
   logic [2*DATA_W-1:0] prod_res;
   logic [DATA_W-1:0]   quo_res, rem_res;
   assign prod_res = neg_res_q ? -acc_q[2*DATA_W-1:0] : acc_q[2*DATA_W-1:0];
   assign quo_res  = div0_q ? '1 : (neg_res_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0]);
   assign rem_res  = neg_rem_q ? -rem_q[DATA_W-1:0] : rem_q[DATA_W-1:0];

   // Next-state, datapath and registered-output computation.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      div0_d    = div0_q;
      dvsr_d    = dvsr_q;
      acc_d     = acc_q;
      rem_d     = rem_q;
      hi_d      = hi_q;
      lo_d      = lo_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start) begin
               state_d   = S_CALC;
               cnt_d     = CNT_LAST;
               is_div_d  = op[1];
               neg_res_d = a_neg ^ b_neg;
               neg_rem_d = a_neg;
               div0_d    = op[1] & (data2 == '0);
               rem_d     = '0;
               if (op[1]) begin
                  dvsr_d = b_mag;
                  acc_d  = {{(DATA_W+1){1'b0}}, a_mag};
               end else begin
                  dvsr_d = a_mag;
                  acc_d  = {{(DATA_W+1){1'b0}}, b_mag};
               end
            end
         end
         S_CALC: begin
            if (is_div_q) begin
               rem_d = div_ge ? div_diff[DATA_W:0] : div_shift[DATA_W:0];
               acc_d = {acc_q[2*DATA_W:DATA_W], acc_q[DATA_W-2:0], div_ge};
            end else begin
               acc_d = mul_next;
            end
            if (cnt_q == '0) state_d = S_SIGN;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         S_SIGN: begin
            state_d = S_DONE;
            if (is_div_q) begin
               hi_d = rem_res;
               lo_d = quo_res;
            end else begin
               hi_d = prod_res[2*DATA_W-1:DATA_W];
               lo_d = prod_res[DATA_W-1:0];
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Abort wins over everything, including a start in the same cycle.
      if (flush) begin
         state_d = S_IDLE;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end

      busy_d = (state_d == S_CALC) || (state_d == S_SIGN);
      done_d = (state_d == S_DONE);
   end

   // State and datapath registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
         dvsr_q    <= '0;
         acc_q     <= '0;
         rem_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         div0_q    <= div0_d;
         dvsr_q    <= dvsr_d;
         acc_q     <= acc_d;
         rem_q     <= rem_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;
endmodule
